mesh_fractal_sync_ctrl: RTL and testbench

- Centralised multi-level barrier controller for an N_TILES_X x N_TILES_Y RedMulE mesh.
- Replaces the fixed, unconnected per-tile sync interfaces with a parametrised hierarchical barrier. Each tile requests synchronisation at a level; level l groups 2^l tiles with consecutive tile IDs.
- Issues a one-cycle done pulse to every group member once all members have arrived at the same level.
- Tracks per-tile wait time and flags timeouts and illegal levels.
- Sits at mesh level between the tiles' sync ports and the mesh control logic.

---
 rtl/mesh_fractal_sync_ctrl.sv | 153 +++++++++++++++
 tb/tb_mesh_fractal_sync_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_fractal_sync_ctrl.sv
// ============================================================================
// mesh_fractal_sync_ctrl : hierarchical multi-level barrier for a tile mesh
// Revision: 1.0
// ============================================================================
`default_nettype none

module mesh_fractal_sync_ctrl #(
   parameter int N_TILES_X      = 2,
   parameter int N_TILES_Y      = 2,
   parameter int N_TILES        = N_TILES_X * N_TILES_Y,
   parameter int LVL_MAX        = $clog2(N_TILES),
   parameter int LVL_WIDTH      = $clog2(N_TILES) + 1,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [N_TILES-1:0]                  sync_req_i,
   input  logic [N_TILES-1:0][LVL_WIDTH-1:0]   sync_lvl_i,
   output logic [N_TILES-1:0]                  sync_done_o,
   output logic [N_TILES-1:0]                  sync_err_o,
   output logic [N_TILES-1:0]                  sync_timeout_o,
   output logic [N_TILES-1:0]                  sync_busy_o,
   output logic [31:0]                         barrier_cnt_o
);

   generate
      if ((N_TILES & (N_TILES - 1)) != 0) begin : g_bad_ntiles
         $error("mesh_fractal_sync_ctrl: N_TILES must be a power of two");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("mesh_fractal_sync_ctrl: TIMEOUT_CYCLES must be >= 1");
      end
   endgenerate

   localparam logic [LVL_WIDTH-1:0] c_lvl_max = LVL_WIDTH'(LVL_MAX);
   localparam logic [CNT_W-1:0]     c_tmo     = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 r_state     [N_TILES];
   state_t                 w_state_nxt [N_TILES];
   logic [LVL_WIDTH-1:0]   r_lvl       [N_TILES];
   logic [CNT_W-1:0]       r_cnt       [N_TILES];
   logic [N_TILES-1:0]     w_complete;
   logic [N_TILES-1:0]     w_legal;
   logic [N_TILES-1:0]     w_done_nxt;
   logic [N_TILES-1:0]     w_err_nxt;
   logic [N_TILES-1:0]     r_done;
   logic [N_TILES-1:0]     r_err;
   logic [31:0]            r_barrier_cnt;

   // A waiting tile completes when every member of its 2^l group waits at the same level.
   always_comb begin
      w_complete = '0;
      for (int t = 0; t < N_TILES; t++) begin
         w_complete[t] = (r_state[t] == ST_WAIT);
         for (int u = 0; u < N_TILES; u++) begin
            if (((u >> r_lvl[t]) == (t >> r_lvl[t])) &&
                !((r_state[u] == ST_WAIT) && (r_lvl[u] == r_lvl[t]))) begin
               w_complete[t] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_legal    = '0;
      w_done_nxt = '0;
      w_err_nxt  = '0;
      for (int t = 0; t < N_TILES; t++) begin
         w_state_nxt[t] = r_state[t];
         w_legal[t]     = (sync_lvl_i[t] != '0) && (sync_lvl_i[t] <= c_lvl_max);
         case (r_state[t])
            ST_IDLE: begin
               if (sync_req_i[t]) begin
                  if (w_legal[t]) begin
                     w_state_nxt[t] = ST_WAIT;
                  end else begin
                     w_state_nxt[t] = ST_DONE;
                     w_done_nxt[t]  = 1'b1;
                     w_err_nxt[t]   = 1'b1;
                  end
               end
            end
            // Request deassertion while waiting is ignored on purpose.
            ST_WAIT: begin
               if (w_complete[t]) begin
                  w_state_nxt[t] = ST_DONE;
                  w_done_nxt[t]  = 1'b1;
               end
            end
            ST_DONE: begin
               if (!sync_req_i[t]) begin
                  w_state_nxt[t] = ST_IDLE;
               end
            end
            default: w_state_nxt[t] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int t = 0; t < N_TILES; t++) begin
            r_state[t] <= ST_IDLE;
            r_lvl[t]   <= '0;
            r_cnt[t]   <= '0;
         end
         r_done        <= '0;
         r_err         <= '0;
         r_barrier_cnt <= '0;
      end else begin
         for (int t = 0; t < N_TILES; t++) begin
            r_state[t] <= w_state_nxt[t];
            if ((r_state[t] == ST_IDLE) && (w_state_nxt[t] == ST_WAIT)) begin
               r_lvl[t] <= sync_lvl_i[t];
               r_cnt[t] <= '0;
            end else if ((r_state[t] == ST_WAIT) && (w_state_nxt[t] == ST_WAIT)) begin
               if (r_cnt[t] != c_tmo) begin
                  r_cnt[t] <= r_cnt[t] + CNT_W'(1);
               end
            end else begin
               r_cnt[t] <= '0;
            end
         end
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
         // Tile 0 belongs to the single full-mesh group, so it stands for that group.
         if (w_complete[0] && (r_lvl[0] == c_lvl_max)) begin
            r_barrier_cnt <= r_barrier_cnt + 32'd1;
         end
      end
   end

   assign sync_done_o   = r_done;
   assign sync_err_o    = r_err;
   assign barrier_cnt_o = r_barrier_cnt;

   generate
      for (genvar t = 0; t < N_TILES; t++) begin : g_tile
         assign sync_busy_o[t]    = (r_state[t] == ST_WAIT);
         assign sync_timeout_o[t] = (r_state[t] == ST_WAIT) && (r_cnt[t] == c_tmo);
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mesh_fractal_sync_ctrl.sv
// ============================================================================
// tb_mesh_fractal_sync_ctrl : directed self-checking bench, 2x2 mesh, timeout 8
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mesh_fractal_sync_ctrl;

   logic             clk;
   logic             rst;
   logic [3:0]       req;
   logic [3:0][2:0]  lvl;
   logic [3:0]       done;
   logic [3:0]       err;
   logic [3:0]       tmo;
   logic [3:0]       busy;
   logic [31:0]      bcnt;

   int n_checks = 0;
   int n_errors = 0;

   mesh_fractal_sync_ctrl #(
      .N_TILES_X      (2),
      .N_TILES_Y      (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .sync_req_i     (req),
      .sync_lvl_i     (lvl),
      .sync_done_o    (done),
      .sync_err_o     (err),
      .sync_timeout_o (tmo),
      .sync_busy_o    (busy),
      .barrier_cnt_o  (bcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req = '0;
      lvl = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req = 4'b1111;
      lvl = {3'd2, 3'd2, 3'd2, 3'd2};
      tick();
      tick();
      n_checks++;
      if (busy !== 4'b0000) begin n_errors++; $display("FAIL reset_busy got %b want 0000", busy); end
      n_checks++;
      if (done !== 4'b0000) begin n_errors++; $display("FAIL reset_done got %b want 0000", done); end
      n_checks++;
      if (err !== 4'b0000) begin n_errors++; $display("FAIL reset_err got %b want 0000", err); end
      n_checks++;
      if (tmo !== 4'b0000) begin n_errors++; $display("FAIL reset_tmo got %b want 0000", tmo); end
      n_checks++;
      if (bcnt !== 32'd0) begin n_errors++; $display("FAIL reset_bcnt got %0d want 0", bcnt); end
      req = '0;
      rst = 1'b0;
   endtask

   task automatic test_full_mesh;
      logic [3:0]  eb, ed, et;
      logic [31:0] ec;
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         if (c == 1) begin req[0] = 1'b1; lvl[0] = 3'd2; end
         if (c == 3) begin req[1] = 1'b1; lvl[1] = 3'd2; end
         if (c == 5) begin req[2] = 1'b1; lvl[2] = 3'd2; end
         if (c == 9) begin req[3] = 1'b1; lvl[3] = 3'd2; end
         tick();
         eb = (c < 3) ? 4'b0001 : (c < 5) ? 4'b0011 : (c < 9) ? 4'b0111 :
              (c == 9) ? 4'b1111 : 4'b0000;
         ed = (c == 10) ? 4'b1111 : 4'b0000;
         et = (c == 9) ? 4'b0001 : 4'b0000;
         ec = (c >= 10) ? 32'd1 : 32'd0;
         n_checks++;
         if (busy !== eb) begin n_errors++; $display("FAIL full_busy c=%0d got %b want %b", c, busy, eb); end
         n_checks++;
         if (done !== ed) begin n_errors++; $display("FAIL full_done c=%0d got %b want %b", c, done, ed); end
         n_checks++;
         if (tmo !== et) begin n_errors++; $display("FAIL full_tmo c=%0d got %b want %b", c, tmo, et); end
         n_checks++;
         if (bcnt !== ec) begin n_errors++; $display("FAIL full_bcnt c=%0d got %0d want %0d", c, bcnt, ec); end
         n_checks++;
         if (err !== 4'b0000) begin n_errors++; $display("FAIL full_err c=%0d got %b want 0000", c, err); end
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_pairwise;
      logic [3:0] eb, ed;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         if (c == 2) begin req[1:0] = 2'b11; lvl[0] = 3'd1; lvl[1] = 3'd1; end
         if (c == 4) begin req[3:2] = 2'b11; lvl[2] = 3'd1; lvl[3] = 3'd1; end
         tick();
         eb = (c == 2) ? 4'b0011 : (c == 4) ? 4'b1100 : 4'b0000;
         ed = (c == 3) ? 4'b0011 : (c == 5) ? 4'b1100 : 4'b0000;
         n_checks++;
         if (busy !== eb) begin n_errors++; $display("FAIL pair_busy c=%0d got %b want %b", c, busy, eb); end
         n_checks++;
         if (done !== ed) begin n_errors++; $display("FAIL pair_done c=%0d got %b want %b", c, done, ed); end
         n_checks++;
         if (bcnt !== 32'd0) begin n_errors++; $display("FAIL pair_bcnt c=%0d got %0d want 0", c, bcnt); end
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_illegal_level;
      logic [2:0] bad [2];
      bad[0] = 3'd0;
      bad[1] = 3'd3;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         req[2] = 1'b1;
         lvl[2] = bad[k];
         tick();
         n_checks++;
         if (done !== 4'b0100) begin n_errors++; $display("FAIL illegal_done lvl=%0d got %b want 0100", bad[k], done); end
         n_checks++;
         if (err !== 4'b0100) begin n_errors++; $display("FAIL illegal_err lvl=%0d got %b want 0100", bad[k], err); end
         n_checks++;
         if (busy !== 4'b0000) begin n_errors++; $display("FAIL illegal_busy lvl=%0d got %b want 0000", bad[k], busy); end
         tick();
         n_checks++;
         if ((done | err) !== 4'b0000) begin
            n_errors++;
            $display("FAIL illegal_pulse_end lvl=%0d got done=%b err=%b want 0000", bad[k], done, err);
         end
         req[2] = 1'b0;
         tick();
      end
   endtask

   task automatic test_timeout;
      logic [3:0] et, eb, ed;
      do_reset();
      for (int c = 1; c <= 15; c++) begin
         if (c == 1) begin req[0] = 1'b1; lvl[0] = 3'd2; end
         if (c == 13) begin
            req[3:1] = 3'b111;
            lvl[1] = 3'd2; lvl[2] = 3'd2; lvl[3] = 3'd2;
         end
         tick();
         et = (c >= 9 && c <= 13) ? 4'b0001 : 4'b0000;
         eb = (c == 13) ? 4'b1111 : (c < 13) ? 4'b0001 : 4'b0000;
         ed = (c == 14) ? 4'b1111 : 4'b0000;
         n_checks++;
         if (tmo !== et) begin n_errors++; $display("FAIL tmo_flag c=%0d got %b want %b", c, tmo, et); end
         n_checks++;
         if (busy !== eb) begin n_errors++; $display("FAIL tmo_busy c=%0d got %b want %b", c, busy, eb); end
         n_checks++;
         if (done !== ed) begin n_errors++; $display("FAIL tmo_done c=%0d got %b want %b", c, done, ed); end
      end
      n_checks++;
      if (bcnt !== 32'd1) begin n_errors++; $display("FAIL tmo_bcnt got %0d want 1", bcnt); end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_held_and_reset;
      logic [3:0] ed;
      do_reset();
      for (int c = 1; c <= 11; c++) begin
         if (c == 1) begin req[1:0] = 2'b11; lvl[0] = 3'd1; lvl[1] = 3'd1; end
         if (c == 3) req[0] = 1'b0;
         if (c == 8) req[1] = 1'b0;
         if (c == 9) req[1:0] = 2'b11;
         if (c == 11) req[1:0] = 2'b00;
         tick();
         ed = (c == 2 || c == 10) ? 4'b0011 : 4'b0000;
         n_checks++;
         if (done !== ed) begin n_errors++; $display("FAIL held_done c=%0d got %b want %b", c, done, ed); end
      end
      tick();
      // Complete one full-mesh barrier so the reset has a counter to clear.
      req = 4'b1111;
      lvl = {3'd2, 3'd2, 3'd2, 3'd2};
      tick();
      tick();
      n_checks++;
      if (bcnt !== 32'd1) begin n_errors++; $display("FAIL held_bcnt_pre got %0d want 1", bcnt); end
      req = '0;
      tick();
      req[1:0] = 2'b11;
      tick();
      tick();
      n_checks++;
      if (busy !== 4'b0011) begin n_errors++; $display("FAIL rst_busy_pre got %b want 0011", busy); end
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (busy !== 4'b0000) begin n_errors++; $display("FAIL rst_busy c=%0d got %b want 0000", c, busy); end
         n_checks++;
         if (done !== 4'b0000) begin n_errors++; $display("FAIL rst_done c=%0d got %b want 0000", c, done); end
         n_checks++;
         if (bcnt !== 32'd0) begin n_errors++; $display("FAIL rst_bcnt c=%0d got %0d want 0", c, bcnt); end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      lvl = '0;
      test_reset();
      test_full_mesh();
      test_pairwise();
      test_illegal_level();
      test_timeout();
      test_held_and_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
